// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register.
// - Default bundle widths.
// - Occupancy encoding.
// - Control-field bit positions.
// - A helper that maps entry valids to an occupancy code.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_MAIN  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Control bundle layout.
    // - ALUOp sits in the low nibble.
    // - The single-bit flags sit above ALUOp.
    // - The 8-bit default bundle carries ALUOp, RegWrite, MemToReg, MemRead and MemWrite.
    // - RWsel and ALUSrc need a bundle of at least CTRL_W_FULL bits.
    localparam int CTRL_ALUOP_LSB = 0;
    localparam int CTRL_ALUOP_W   = 4;
    localparam int CTRL_REGWRITE  = 4;
    localparam int CTRL_MEMTOREG  = 5;
    localparam int CTRL_MEMREAD   = 6;
    localparam int CTRL_MEMWRITE  = 7;
    localparam int CTRL_RWSEL     = 8;
    localparam int CTRL_ALUSRC    = 9;
    localparam int CTRL_W_FULL    = 10;

    // The skid entry is only ever filled while the main entry is full,
    // so the two valids map directly onto an occupancy code.
    function automatic occ_e occ_of(input logic main_valid, input logic skid_valid);
        if (skid_valid)
            return OCC_FULL;
        else if (main_valid)
            return OCC_MAIN;
        else
            return OCC_EMPTY;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel that carries one pipeline instruction.
// - valid : producer holds a valid instruction
// - ready : consumer can accept this cycle
// - ctrl  : control bundle (CTRL_W bits)
// - data  : data bundle (DATA_W bits)
// Modports:
// - master : producer side
// - slave  : consumer side
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) ();

    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);

endinterface

// File: rtl/pipe_skid_entry.sv
// One pipeline entry: a valid bit, a control bundle and a data bundle.
// Ports:
// - clk, rst         : clock, async active-high reset
// - clr              : sync clear; drops the entry and zeroes ctrl
// - load             : capture in_ctrl/in_data and mark the entry valid
// - in_ctrl, in_data : bundle to capture
// - valid, ctrl, data: held entry
// Behaviour:
// - clr has priority over load.
// - data is left untouched on clear, so it stays stable while the entry is empty.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // NOTE: every flop here, data included, is cleared by the async reset.
    // This makes a mid-operation reset wipe the skid entry at once.
    // State updates use non-blocking assignments.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake on both sides.
// Ports:
// - clk, rst  : clock, async active-high reset
// - up        : upstream channel (valid/ctrl/data in, ready out)
// - dn        : downstream channel (valid/ctrl/data out, ready in)
// - stall     : hold everything; no transfer in or out
// - flush     : drop all held entries and the one being offered
// - occupancy : number of entries held (0..2)
// Build options:
// - SKID_EN=1 : a main + skid entry pair; up.ready comes straight from a flop.
// - SKID_EN=0 : a single entry; up.ready is combinational from dn.ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CTRL_W  = CTRL_W_DEF,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    pipe_stage_reg_if.slave         up,
    pipe_stage_reg_if.master        dn,
    input  logic                    stall,
    input  logic                    flush,
    output logic [1:0]              occupancy
);

    logic              in_xfer;
    logic              out_xfer;
    logic              main_valid;
    logic              main_load;
    logic              main_clr;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_in_ctrl;
    logic [DATA_W-1:0] main_in_data;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    assign in_xfer  = up.valid & up.ready & ~stall & ~flush;
    assign out_xfer = main_valid & dn.ready & ~stall;

    // The main entry loads when it is free, or when it is being drained
    // and something is waiting. A waiting skid entry goes first, so order is kept.
    assign main_load    = (~main_valid | out_xfer) & (skid_valid | in_xfer);
    assign main_clr     = flush | (out_xfer & ~skid_valid & ~in_xfer);
    assign main_in_ctrl = skid_valid ? skid_ctrl : up.ctrl;
    assign main_in_data = skid_valid ? skid_data : up.data;

    pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr     (main_clr),
        .load    (main_load),
        .in_ctrl (main_in_ctrl),
        .in_data (main_in_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    generate
        if (SKID_EN) begin : g_skid
            logic skid_load;
            logic skid_clr;
            logic skid_next;
            logic ready_q;

            // A new entry parks in the skid only while main is held.
            // The skid empties whenever main drains, because it then moves into main.
            assign skid_load = in_xfer & main_valid & ~out_xfer;
            assign skid_clr  = flush | out_xfer;
            assign skid_next = ~flush & ~out_xfer & (skid_valid | (in_xfer & main_valid));

            pipe_skid_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .clr     (skid_clr),
                .load    (skid_load),
                .in_ctrl (up.ctrl),
                .in_data (up.data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );

            // Registered ready: it tracks whether the skid will be free after this edge.
            // This keeps dn.ready off the upstream ready path.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    ready_q <= 1'b0;
                else
                    ready_q <= ~skid_next;
            end

            assign up.ready = ready_q;
        end else begin : g_noskid
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
            assign up.ready   = ~rst & (~main_valid | (dn.ready & ~stall));
        end
    endgenerate

    assign dn.valid  = main_valid;
    assign dn.ctrl   = main_ctrl;
    assign dn.data   = main_data;
    assign occupancy = occ_of(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_ctrl;
    logic [31:0] in_data;
    logic        stall;
    logic        flush;
    logic        out_ready;
    logic [1:0]  occ0;
    logic [1:0]  occ1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) u0 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) d0 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) u1 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(8)) d1 ();

    assign u0.valid = in_valid;
    assign u0.ctrl  = in_ctrl;
    assign u0.data  = in_data;
    assign d0.ready = out_ready;
    assign u1.valid = in_valid;
    assign u1.ctrl  = in_ctrl;
    assign u1.data  = in_data;
    assign d1.ready = out_ready;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b1)) dut_skid (
        .clk(clk), .rst(rst), .up(u0), .dn(d0),
        .stall(stall), .flush(flush), .occupancy(occ0)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID_EN(1'b0)) dut_noskid (
        .clk(clk), .rst(rst), .up(u1), .dn(d1),
        .stall(stall), .flush(flush), .occupancy(occ1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: each stage is an in-order FIFO.
    // Its capacity is enforced through the handshake rules.
    ent_t q0[$];
    ent_t q1[$];
    bit   rdy0 = 1'b0;
    bit   ix0, ox0, ix1, ox1, rdy1;

    function automatic bit exp_rdy1();
        return !rst && (q1.size() == 0 || (out_ready && !stall));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q0.delete();
            q1.delete();
            rdy0 = 1'b0;
        end else begin
            rdy1 = exp_rdy1();
            ix0  = in_valid && rdy0 && !stall && !flush;
            ox0  = q0.size() > 0 && out_ready && !stall;
            ix1  = in_valid && rdy1 && !stall && !flush;
            ox1  = q1.size() > 0 && out_ready && !stall;
            if (flush) begin
                q0.delete();
                q1.delete();
            end else begin
                if (ox0) void'(q0.pop_front());
                if (ix0) q0.push_back('{ctrl: in_ctrl, data: in_data});
                if (ox1) void'(q1.pop_front());
                if (ix1) q1.push_back('{ctrl: in_ctrl, data: in_data});
            end
            rdy0 = q0.size() < 2;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("skid.rst_out_valid", {31'd0, d0.valid}, 32'd0);
            check("skid.rst_out_ctrl", {24'd0, d0.ctrl}, 32'd0);
            check("skid.rst_occupancy", {30'd0, occ0}, 32'd0);
            check("skid.rst_in_ready", {31'd0, u0.ready}, 32'd0);
            check("noskid.rst_out_valid", {31'd0, d1.valid}, 32'd0);
            check("noskid.rst_in_ready", {31'd0, u1.ready}, 32'd0);
        end else begin
            check("skid.out_valid", {31'd0, d0.valid}, {31'd0, q0.size() != 0});
            check("skid.occupancy", {30'd0, occ0}, 32'(q0.size()));
            check("skid.in_ready", {31'd0, u0.ready}, {31'd0, rdy0});
            check("skid.out_ctrl", {24'd0, d0.ctrl}, q0.size() != 0 ? {24'd0, q0[0].ctrl} : 32'd0);
            if (q0.size() != 0) check("skid.out_data", d0.data, q0[0].data);
            check("noskid.out_valid", {31'd0, d1.valid}, {31'd0, q1.size() != 0});
            check("noskid.occupancy", {30'd0, occ1}, 32'(q1.size()));
            check("noskid.in_ready", {31'd0, u1.ready}, {31'd0, exp_rdy1()});
            check("noskid.out_ctrl", {24'd0, d1.ctrl}, q1.size() != 0 ? {24'd0, q1[0].ctrl} : 32'd0);
            if (q1.size() != 0) check("noskid.out_data", d1.data, q1[0].data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_two(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = c;
        in_data   = a;
        tick();
        in_data = b;
        tick();
        check("fill.occupancy_full", {30'd0, occ0}, 32'd2);
        check("fill.out_ctrl", {24'd0, d0.ctrl}, {24'd0, c});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_ctrl   = 8'h00;
        in_data   = 32'h0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("init.out_valid", {31'd0, d0.valid}, 32'd0);
        check("init.occupancy", {30'd0, occ0}, 32'd0);
        check("init.in_ready", {31'd0, u0.ready}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("release.ready_before_edge", {31'd0, u0.ready}, 32'd0);
        tick();
        check("release.ready_after_edge", {31'd0, u0.ready}, 32'd1);

        // Streaming: one accept per cycle, each visible one cycle later.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_data = 32'(i);
            in_ctrl = 8'(i);
            tick();
            check("stream.skid_data", d0.data, 32'(i));
            check("stream.noskid_data", d1.data, 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream.drained", {31'd0, d0.valid}, 32'd0);

        // Backpressure: A, B fill the stage; C only after both leave.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h21;
        in_data   = 32'hA;
        tick();
        check("bp.first_out", d0.data, 32'hA);
        check("bp.noskid_ready_low", {31'd0, u1.ready}, 32'd0);
        check("bp.noskid_occ", {30'd0, occ1}, 32'd1);
        in_data = 32'hB;
        tick();
        check("bp.occ_full", {30'd0, occ0}, 32'd2);
        check("bp.ready_low", {31'd0, u0.ready}, 32'd0);
        check("bp.head_kept", d0.data, 32'hA);
        in_data   = 32'hC;
        out_ready = 1'b1;
        #1;
        check("bp.noskid_ready_same_cycle", {31'd0, u1.ready}, 32'd1);
        tick();
        check("bp.second_out", d0.data, 32'hB);
        check("bp.occ_after_pop", {30'd0, occ0}, 32'd1);
        tick();
        check("bp.third_out", d0.data, 32'hC);
        in_valid = 1'b0;
        repeat (2) tick();
        check("bp.empty", {30'd0, occ0}, 32'd0);

        // Stall: head holds, nothing is accepted, then transfer resumes.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h3C;
        in_data   = 32'h55;
        tick();
        check("stall.head", d0.data, 32'h55);
        stall     = 1'b1;
        out_ready = 1'b1;
        in_data   = 32'h66;
        repeat (3) begin
            tick();
            check("stall.data_held", d0.data, 32'h55);
            check("stall.valid_held", {31'd0, d0.valid}, 32'd1);
            check("stall.occ_held", {30'd0, occ0}, 32'd1);
            check("stall.noskid_ready_gated", {31'd0, u1.ready}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("stall.resume", d0.data, 32'h66);
        in_valid = 1'b0;
        repeat (2) tick();

        // Flush with a full stage and a concurrent offer of 0x77.
        fill_two(32'h1A, 32'h1B, 8'hFF);
        flush     = 1'b1;
        in_data   = 32'h77;
        out_ready = 1'b1;
        tick();
        check("flush.out_valid", {31'd0, d0.valid}, 32'd0);
        check("flush.out_ctrl", {24'd0, d0.ctrl}, 32'd0);
        check("flush.occupancy", {30'd0, occ0}, 32'd0);
        check("flush.no_memwrite", {31'd0, d0.ctrl[CTRL_MEMWRITE]}, 32'd0);
        check("flush.no_regwrite", {31'd0, d0.ctrl[CTRL_REGWRITE]}, 32'd0);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush.no_77", {31'd0, d0.valid}, 32'd0);

        // Flush together with stall: flush wins.
        fill_two(32'h1C, 32'h1D, 8'hFF);
        flush   = 1'b1;
        stall   = 1'b1;
        in_data = 32'h77;
        tick();
        check("flush_stall.out_valid", {31'd0, d0.valid}, 32'd0);
        check("flush_stall.out_ctrl", {24'd0, d0.ctrl}, 32'd0);
        check("flush_stall.occupancy", {30'd0, occ0}, 32'd0);
        flush    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("flush_stall.no_77", {31'd0, d0.valid}, 32'd0);

        // Async reset mid-stream with both entries held.
        fill_two(32'h2A, 32'h2B, 8'h5A);
        #2;
        rst = 1'b1;
        #1;
        check("rst.same_cycle_valid", {31'd0, d0.valid}, 32'd0);
        check("rst.same_cycle_ctrl", {24'd0, d0.ctrl}, 32'd0);
        check("rst.same_cycle_occ", {30'd0, occ0}, 32'd0);
        check("rst.same_cycle_ready", {31'd0, u0.ready}, 32'd0);
        in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        check("rst.ready_before_edge", {31'd0, u0.ready}, 32'd0);
        tick();
        check("rst.ready_after_edge", {31'd0, u0.ready}, 32'd1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
